// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit bus CPU control path.
// Opcodes, one-hot T-state constants and the strobe bundle.
package cpu8_pkg;

  localparam int OPW     = 4;
  localparam int NTSTATE = 6;

  localparam logic [OPW-1:0] OP_NOP  = 4'h0;
  localparam logic [OPW-1:0] OP_LDA  = 4'h1;
  localparam logic [OPW-1:0] OP_ADD  = 4'h2;
  localparam logic [OPW-1:0] OP_SUB  = 4'h3;
  localparam logic [OPW-1:0] OP_STA  = 4'h4;
  localparam logic [OPW-1:0] OP_LDI  = 4'h5;
  localparam logic [OPW-1:0] OP_JMP  = 4'h6;
  localparam logic [OPW-1:0] OP_JC   = 4'h7;
  localparam logic [OPW-1:0] OP_JZ   = 4'h8;
  localparam logic [OPW-1:0] OP_MOVB = 4'h9;
  localparam logic [OPW-1:0] OP_MOVC = 4'hA;
  localparam logic [OPW-1:0] OP_IN   = 4'hB;
  localparam logic [OPW-1:0] OP_OUT  = 4'hE;
  localparam logic [OPW-1:0] OP_HLT  = 4'hF;

  localparam logic [NTSTATE-1:0] T1 = 6'b000001;
  localparam logic [NTSTATE-1:0] T2 = 6'b000010;
  localparam logic [NTSTATE-1:0] T3 = 6'b000100;
  localparam logic [NTSTATE-1:0] T4 = 6'b001000;
  localparam logic [NTSTATE-1:0] T5 = 6'b010000;
  localparam logic [NTSTATE-1:0] T6 = 6'b100000;

  typedef struct packed {
    logic count_pc;
    logic clear_pc;
    logic enable_pc;
    logic load_pc;
    logic load_mar;
    logic ce_ram;
    logic we_ram;
    logic load_accum;
    logic enable_accum;
    logic sub_mode;
    logic enable_alu;
    logic load_temp_reg;
    logic load_b_reg;
    logic load_c_reg;
    logic load_output_reg;
    logic load_inst_reg;
    logic enable_inst_reg;
    logic clear_inst_reg;
    logic enable_input;
  } ctrl_t;

endpackage

// File: rtl/cpu_control_sequencer_if.sv
// Control bundle between sequencer and datapath.
// master = sequencer, slave = datapath.
interface cpu_control_sequencer_if;
  import cpu8_pkg::*;

  logic [OPW-1:0] opcode;
  logic zero_flag;
  logic carry_flag;
  logic count_pc;
  logic clear_pc;
  logic enable_pc;
  logic load_pc;
  logic load_mar;
  logic ce_ram;
  logic we_ram;
  logic load_accum;
  logic enable_accum;
  logic sub_mode;
  logic enable_alu;
  logic load_temp_reg;
  logic load_b_reg;
  logic load_c_reg;
  logic load_output_reg;
  logic load_inst_reg;
  logic enable_inst_reg;
  logic clear_inst_reg;
  logic enable_input;

  modport master (
    input  opcode, zero_flag, carry_flag,
    output count_pc, clear_pc, enable_pc, load_pc,
    output load_mar, ce_ram, we_ram,
    output load_accum, enable_accum, sub_mode, enable_alu,
    output load_temp_reg, load_b_reg, load_c_reg,
    output load_output_reg,
    output load_inst_reg, enable_inst_reg, clear_inst_reg,
    output enable_input
  );

  modport slave (
    output opcode, zero_flag, carry_flag,
    input  count_pc, clear_pc, enable_pc, load_pc,
    input  load_mar, ce_ram, we_ram,
    input  load_accum, enable_accum, sub_mode, enable_alu,
    input  load_temp_reg, load_b_reg, load_c_reg,
    input  load_output_reg,
    input  load_inst_reg, enable_inst_reg, clear_inst_reg,
    input  enable_input
  );

endinterface

// File: rtl/t_state_ring.sv
// One-hot T-state ring counter.
// restart forces T1 and wins over adv.
module t_state_ring
  import cpu8_pkg::*;
(
  input  logic               clk,
  input  logic               clear_n,
  input  logic               adv,
  input  logic               restart,
  output logic [NTSTATE-1:0] ring
);

  // rotate the single hot bit on advance
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)
      ring <= T1;
    else if (restart)
      ring <= T1;
    else if (adv)
      ring <= {ring[NTSTATE-2:0], ring[NTSTATE-1]};
  end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Microsequencer: T-state ring, opcode decode, strobes.
// Optional single-step: define SEQ_SINGLE_STEP_EN.
module cpu_control_sequencer
  import cpu8_pkg::*;
(
  input  logic                    clk,
  input  logic                    clear_n,
  input  logic                    run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                    step_mode,
  input  logic                    step,
`endif
  cpu_control_sequencer_if.master bus,
  output logic [NTSTATE-1:0]      t_state,
  output logic                    halted
);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_HALT
  } state_t;

  state_t             st;
  state_t             nxt;
  logic [NTSTATE-1:0] ring;
  logic               adv;
  logic               rst1;
  logic               cap;
  logic               fin;
  logic               go;
  logic               zf_q;
  logic               cf_q;
  ctrl_t              c;
  ctrl_t              o;
  logic [OPW-1:0]     op;

  assign op = bus.opcode;

`ifdef SEQ_SINGLE_STEP_EN
  logic [2:0] sy;

  // two-flop synchroniser plus one flop for edge detect
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)
      sy <= '0;
    else
      sy <= {sy[1:0], step};
  end

  assign go = !step_mode | (sy[1] & ~sy[2]);
`else
  assign go = 1'b1;
`endif

  t_state_ring u_ring (
    .clk     (clk),
    .clear_n (clear_n),
    .adv     (adv),
    .restart (rst1),
    .ring    (ring)
  );

  // sequencer state and captured ALU flags
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      st   <= S_INIT;
      zf_q <= 1'b0;
      cf_q <= 1'b0;
    end else begin
      st <= nxt;
      if (cap) begin
        zf_q <= bus.zero_flag;
        cf_q <= bus.carry_flag;
      end
    end
  end

  // next-state, ring control and strobe decode
  always_comb begin
    c    = '0;
    nxt  = st;
    adv  = 1'b0;
    rst1 = 1'b0;
    cap  = 1'b0;
    fin  = 1'b0;
    unique case (st)
      S_INIT: begin
        c.clear_pc       = 1'b1;
        c.clear_inst_reg = 1'b1;
        nxt              = S_RUN;
        rst1             = 1'b1;
      end
      S_RUN: begin
        unique case (1'b1)
          ring[0]: begin
            if (run) begin
              c.enable_pc = 1'b1;
              c.load_mar  = 1'b1;
              adv         = 1'b1;
            end
          end
          ring[1]: begin
            c.count_pc = 1'b1;
            adv        = 1'b1;
          end
          ring[2]: begin
            c.ce_ram        = 1'b1;
            c.load_inst_reg = 1'b1;
            adv             = 1'b1;
          end
          ring[3]: begin
            fin = 1'b1;
            unique case (op)
              OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                c.enable_inst_reg = 1'b1;
                c.load_mar        = 1'b1;
                fin               = 1'b0;
              end
              OP_LDI: begin
                c.enable_inst_reg = 1'b1;
                c.load_accum      = 1'b1;
              end
              OP_JMP: begin
                c.enable_inst_reg = 1'b1;
                c.load_pc         = 1'b1;
              end
              OP_JC: begin
                c.enable_inst_reg = cf_q;
                c.load_pc         = cf_q;
              end
              OP_JZ: begin
                c.enable_inst_reg = zf_q;
                c.load_pc         = zf_q;
              end
              OP_MOVB: begin
                c.enable_accum = 1'b1;
                c.load_b_reg   = 1'b1;
              end
              OP_MOVC: begin
                c.enable_accum = 1'b1;
                c.load_c_reg   = 1'b1;
              end
              OP_IN: begin
                c.enable_input = 1'b1;
                c.load_accum   = 1'b1;
              end
              OP_OUT: begin
                c.enable_accum    = 1'b1;
                c.load_output_reg = 1'b1;
              end
              OP_HLT: nxt = S_HALT;
              default: ;
            endcase
            adv  = !fin;
            rst1 = fin;
          end
          ring[4]: begin
            fin = 1'b1;
            unique case (op)
              OP_LDA: begin
                c.ce_ram     = 1'b1;
                c.load_accum = 1'b1;
              end
              OP_ADD, OP_SUB: begin
                c.ce_ram        = 1'b1;
                c.load_temp_reg = 1'b1;
                fin             = 1'b0;
              end
              OP_STA: begin
                c.enable_accum = 1'b1;
                c.ce_ram       = 1'b1;
                c.we_ram       = 1'b1;
              end
              default: ;
            endcase
            adv  = !fin;
            rst1 = fin;
          end
          ring[5]: begin
            rst1 = 1'b1;
            if (op == OP_ADD || op == OP_SUB) begin
              c.enable_alu = 1'b1;
              c.load_accum = 1'b1;
              c.sub_mode   = (op == OP_SUB);
              cap          = 1'b1;
            end
          end
          default: rst1 = 1'b1;
        endcase
      end
      S_HALT: ;
      default: nxt = S_INIT;
    endcase
    if (!go) begin
      c    = '0;
      nxt  = st;
      adv  = 1'b0;
      rst1 = 1'b0;
      cap  = 1'b0;
    end
  end

  // strobes forced low while reset is held
  assign o = clear_n ? c : '0;

  assign bus.count_pc        = o.count_pc;
  assign bus.clear_pc        = o.clear_pc;
  assign bus.enable_pc       = o.enable_pc;
  assign bus.load_pc         = o.load_pc;
  assign bus.load_mar        = o.load_mar;
  assign bus.ce_ram          = o.ce_ram;
  assign bus.we_ram          = o.we_ram;
  assign bus.load_accum      = o.load_accum;
  assign bus.enable_accum    = o.enable_accum;
  assign bus.sub_mode        = o.sub_mode;
  assign bus.enable_alu      = o.enable_alu;
  assign bus.load_temp_reg   = o.load_temp_reg;
  assign bus.load_b_reg      = o.load_b_reg;
  assign bus.load_c_reg      = o.load_c_reg;
  assign bus.load_output_reg = o.load_output_reg;
  assign bus.load_inst_reg   = o.load_inst_reg;
  assign bus.enable_inst_reg = o.enable_inst_reg;
  assign bus.clear_inst_reg  = o.clear_inst_reg;
  assign bus.enable_input    = o.enable_input;

  assign t_state = (st == S_RUN) ? ring : '0;
  assign halted  = (st == S_HALT);

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Directed bench for cpu_control_sequencer.
// Strobes compared as a 19-bit vector.
module tb_cpu_control_sequencer;
  import cpu8_pkg::*;

  localparam logic [18:0] M_CPC  = 19'd1 << 18;
  localparam logic [18:0] M_CLP  = 19'd1 << 17;
  localparam logic [18:0] M_EPC  = 19'd1 << 16;
  localparam logic [18:0] M_LPC  = 19'd1 << 15;
  localparam logic [18:0] M_LMAR = 19'd1 << 14;
  localparam logic [18:0] M_CE   = 19'd1 << 13;
  localparam logic [18:0] M_WE   = 19'd1 << 12;
  localparam logic [18:0] M_LACC = 19'd1 << 11;
  localparam logic [18:0] M_EACC = 19'd1 << 10;
  localparam logic [18:0] M_SUB  = 19'd1 << 9;
  localparam logic [18:0] M_EALU = 19'd1 << 8;
  localparam logic [18:0] M_LTMP = 19'd1 << 7;
  localparam logic [18:0] M_LB   = 19'd1 << 6;
  localparam logic [18:0] M_LC   = 19'd1 << 5;
  localparam logic [18:0] M_LOUT = 19'd1 << 4;
  localparam logic [18:0] M_LIR  = 19'd1 << 3;
  localparam logic [18:0] M_EIR  = 19'd1 << 2;
  localparam logic [18:0] M_CIR  = 19'd1 << 1;
  localparam logic [18:0] M_EIN  = 19'd1 << 0;

  localparam logic [18:0] F_T1 = M_EPC | M_LMAR;
  localparam logic [18:0] F_T2 = M_CPC;
  localparam logic [18:0] F_T3 = M_CE | M_LIR;

  logic clk = 1'b0;
  logic clear_n;
  logic run;
  logic [5:0] t_state;
  logic halted;
  int total = 0;
  int bad = 0;

  cpu_control_sequencer_if bus ();

  cpu_control_sequencer dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .run       (run),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode (1'b0),
    .step      (1'b0),
`endif
    .bus       (bus),
    .t_state   (t_state),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] obs();
    return {bus.count_pc, bus.clear_pc, bus.enable_pc,
            bus.load_pc, bus.load_mar, bus.ce_ram,
            bus.we_ram, bus.load_accum, bus.enable_accum,
            bus.sub_mode, bus.enable_alu, bus.load_temp_reg,
            bus.load_b_reg, bus.load_c_reg,
            bus.load_output_reg, bus.load_inst_reg,
            bus.enable_inst_reg, bus.clear_inst_reg,
            bus.enable_input};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // bus-driver exclusivity, every cycle
  always @(negedge clk) begin : inv
    int n;
    if (clear_n === 1'b1) begin
      n = $countones({bus.enable_pc, bus.enable_accum,
                      bus.enable_alu, bus.enable_inst_reg,
                      bus.enable_input,
                      bus.ce_ram & ~bus.we_ram});
      total++;
      if (n > 1) begin
        bad++;
        $display("FAIL bus_onehot drivers=%0d need<=1 t=%0t",
                 n, $time);
      end
    end
  end

  task automatic test_reset();
    clear_n = 1'b0;
    run = 1'b1;
    bus.opcode = OP_NOP;
    bus.zero_flag = 1'b0;
    bus.carry_flag = 1'b0;
    #3;
    total++;
    if (obs() !== 19'd0 || t_state !== 6'd0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL rst_hold strobes=%h t=%b h=%b need 0",
               obs(), t_state, halted);
    end
    repeat (2) @(posedge clk);
    #1;
    clear_n = 1'b1;
    #1;
    total++;
    if (obs() !== (M_CLP | M_CIR) || t_state !== 6'd0) begin
      bad++;
      $display("FAIL rst_init strobes=%h t=%b need %h t=0",
               obs(), t_state, M_CLP | M_CIR);
    end
    cyc();
    total++;
    if (obs() !== F_T1 || t_state !== T1) begin
      bad++;
      $display("FAIL rst_t1 strobes=%h t=%b need %h t=%b",
               obs(), t_state, F_T1, T1);
    end
  endtask

  task automatic test_reset_mid();
    bus.opcode = OP_ADD;
    repeat (4) cyc();
    total++;
    if (obs() !== (M_CE | M_LTMP) || t_state !== T5) begin
      bad++;
      $display("FAIL mid_t5 strobes=%h t=%b need %h",
               obs(), t_state, M_CE | M_LTMP);
    end
    #2;
    clear_n = 1'b0;
    #1;
    total++;
    if (obs() !== 19'd0 || t_state !== 6'd0) begin
      bad++;
      $display("FAIL mid_rst strobes=%h t=%b need 0",
               obs(), t_state);
    end
    cyc();
    clear_n = 1'b1;
    #1;
    total++;
    if (obs() !== (M_CLP | M_CIR) || t_state !== 6'd0) begin
      bad++;
      $display("FAIL mid_init strobes=%h need %h",
               obs(), M_CLP | M_CIR);
    end
    cyc();
    total++;
    if (obs() !== F_T1 || t_state !== T1) begin
      bad++;
      $display("FAIL mid_t1 strobes=%h t=%b need %h",
               obs(), t_state, F_T1);
    end
  endtask

  task automatic test_ldi_out();
    logic [3:0] ops [2];
    logic [18:0] t4 [2];
    ops = '{OP_LDI, OP_OUT};
    t4 = '{M_EIR | M_LACC, M_EACC | M_LOUT};
    for (int k = 0; k < 2; k++) begin
      logic [18:0] e [4];
      e = '{F_T1, F_T2, F_T3, t4[k]};
      bus.opcode = ops[k];
      #1;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obs() !== e[i] || t_state !== (6'd1 << i)) begin
          bad++;
          $display("FAIL op%h_c%0d strobes=%h t=%b need %h",
                   ops[k], i, obs(), t_state, e[i]);
        end
        cyc();
      end
      total++;
      if (t_state !== T1) begin
        bad++;
        $display("FAIL op%h_len t=%b need %b",
                 ops[k], t_state, T1);
      end
    end
  endtask

  task automatic test_misc_t4();
    logic [3:0] ops [5];
    logic [18:0] t4 [5];
    ops = '{OP_NOP, OP_MOVB, OP_MOVC, OP_IN, OP_JMP};
    t4 = '{19'd0, M_EACC | M_LB, M_EACC | M_LC,
           M_EIN | M_LACC, M_EIR | M_LPC};
    for (int k = 0; k < 5; k++) begin
      bus.opcode = ops[k];
      repeat (3) cyc();
      total++;
      if (obs() !== t4[k] || t_state !== T4) begin
        bad++;
        $display("FAIL misc%h_t4 strobes=%h t=%b need %h",
                 ops[k], obs(), t_state, t4[k]);
      end
      cyc();
      total++;
      if (t_state !== T1) begin
        bad++;
        $display("FAIL misc%h_len t=%b need %b",
                 ops[k], t_state, T1);
      end
    end
  endtask

  task automatic test_flags();
    logic [18:0] e [6];
    e = '{F_T1, F_T2, F_T3, M_EIR | M_LMAR,
          M_CE | M_LTMP, M_EALU | M_LACC};
    bus.opcode = OP_ADD;
    bus.zero_flag = 1'b1;
    bus.carry_flag = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (obs() !== e[i] || t_state !== (6'd1 << i)) begin
        bad++;
        $display("FAIL add_c%0d strobes=%h t=%b need %h",
                 i, obs(), t_state, e[i]);
      end
      cyc();
    end
    total++;
    if (t_state !== T1) begin
      bad++;
      $display("FAIL add_len t=%b need %b", t_state, T1);
    end
    bus.zero_flag = 1'b0;
    bus.carry_flag = 1'b0;
    bus.opcode = OP_JZ;
    repeat (3) cyc();
    total++;
    if (obs() !== (M_EIR | M_LPC)) begin
      bad++;
      $display("FAIL jz_taken strobes=%h need %h",
               obs(), M_EIR | M_LPC);
    end
    cyc();
    bus.opcode = OP_JC;
    repeat (3) cyc();
    total++;
    if (obs() !== (M_EIR | M_LPC)) begin
      bad++;
      $display("FAIL jc_taken strobes=%h need %h",
               obs(), M_EIR | M_LPC);
    end
    cyc();
    bus.opcode = OP_ADD;
    repeat (6) cyc();
    bus.zero_flag = 1'b1;
    bus.opcode = OP_JZ;
    repeat (3) cyc();
    total++;
    if (obs() !== 19'd0 || t_state !== T4) begin
      bad++;
      $display("FAIL jz_not strobes=%h t=%b need 0",
               obs(), t_state);
    end
    cyc();
    bus.zero_flag = 1'b0;
    total++;
    if (t_state !== T1) begin
      bad++;
      $display("FAIL jz_len t=%b need %b", t_state, T1);
    end
  endtask

  task automatic test_sta_lda();
    logic [3:0] ops [2];
    logic [18:0] t5 [2];
    ops = '{OP_STA, OP_LDA};
    t5 = '{M_EACC | M_CE | M_WE, M_CE | M_LACC};
    for (int k = 0; k < 2; k++) begin
      logic [18:0] e [5];
      e = '{F_T1, F_T2, F_T3, M_EIR | M_LMAR, t5[k]};
      bus.opcode = ops[k];
      #1;
      for (int i = 0; i < 5; i++) begin
        total++;
        if (obs() !== e[i] || t_state !== (6'd1 << i)) begin
          bad++;
          $display("FAIL mem%h_c%0d strobes=%h t=%b need %h",
                   ops[k], i, obs(), t_state, e[i]);
        end
        cyc();
      end
      total++;
      if (t_state !== T1) begin
        bad++;
        $display("FAIL mem%h_len t=%b need %b",
                 ops[k], t_state, T1);
      end
    end
  endtask

  task automatic test_halt();
    int hb;
    bus.opcode = OP_HLT;
    repeat (3) cyc();
    total++;
    if (obs() !== 19'd0 || t_state !== T4 || halted !== 1'b0) begin
      bad++;
      $display("FAIL hlt_t4 strobes=%h t=%b h=%b need 0 T4 0",
               obs(), t_state, halted);
    end
    cyc();
    total++;
    if (halted !== 1'b1 || t_state !== 6'd0) begin
      bad++;
      $display("FAIL hlt_enter h=%b t=%b need 1 0",
               halted, t_state);
    end
    hb = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (halted !== 1'b1 || obs() !== 19'd0 || t_state !== 6'd0)
        hb++;
    end
    total++;
    if (hb !== 0) begin
      bad++;
      $display("FAIL hlt_hold badcycles=%0d need 0", hb);
    end
    clear_n = 1'b0;
    #2;
    clear_n = 1'b1;
    #1;
    total++;
    if (halted !== 1'b0 || obs() !== (M_CLP | M_CIR)) begin
      bad++;
      $display("FAIL hlt_init h=%b strobes=%h need 0 %h",
               halted, obs(), M_CLP | M_CIR);
    end
    bus.opcode = OP_NOP;
    cyc();
    total++;
    if (obs() !== F_T1 || t_state !== T1) begin
      bad++;
      $display("FAIL hlt_t1 strobes=%h t=%b need %h",
               obs(), t_state, F_T1);
    end
  endtask

  task automatic test_run_pause();
    int pb;
    bus.opcode = OP_SUB;
    repeat (4) cyc();
    run = 1'b0;
    #1;
    total++;
    if (obs() !== (M_CE | M_LTMP) || t_state !== T5) begin
      bad++;
      $display("FAIL pause_t5 strobes=%h t=%b need %h",
               obs(), t_state, M_CE | M_LTMP);
    end
    cyc();
    total++;
    if (obs() !== (M_EALU | M_LACC | M_SUB) || t_state !== T6) begin
      bad++;
      $display("FAIL pause_t6 strobes=%h t=%b need %h",
               obs(), t_state, M_EALU | M_LACC | M_SUB);
    end
    cyc();
    total++;
    if (obs() !== 19'd0 || t_state !== T1) begin
      bad++;
      $display("FAIL pause_park strobes=%h t=%b need 0 T1",
               obs(), t_state);
    end
    pb = 0;
    repeat (3) begin
      cyc();
      if (obs() !== 19'd0 || t_state !== T1)
        pb++;
    end
    total++;
    if (pb !== 0) begin
      bad++;
      $display("FAIL pause_hold badcycles=%0d need 0", pb);
    end
    run = 1'b1;
    #1;
    total++;
    if (obs() !== F_T1) begin
      bad++;
      $display("FAIL resume_t1 strobes=%h need %h", obs(), F_T1);
    end
    cyc();
    total++;
    if (obs() !== F_T2 || t_state !== T2) begin
      bad++;
      $display("FAIL resume_t2 strobes=%h t=%b need %h",
               obs(), t_state, F_T2);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_ldi_out();
    test_misc_t4();
    test_flags();
    test_sta_lda();
    test_halt();
    test_run_pause();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
